vga_pixel_gen: RTL
==================

Name: vga_pixel_gen

Overview:
- Downstream consumer of the VGA timing generator's hs, vs, hcount and vcount.
- Converts the raster position into a scaled framebuffer read address and fetches RGB332 pixels from an external synchronous RAM.
- Drives colour outputs with blanking and optional border overlay, and delays hs/vs to stay aligned with the pixel data.
- Runs in the pixel clock domain, 25 MHz for 640x480 and 40 MHz for 800x600.

Parameters:
- RD_LATENCY, 1: framebuffer read latency in clocks, from fb_addr/fb_rd_en registered to fb_rd_data valid; legal range 1..4.
- ADDR_W, 17: framebuffer address width.
- SCALE_SHIFT, 1: pixel replication factor as a power of two; 1 gives a 2x2 replicate.
- BORDER_COLOR, 8'hE0: RGB332 value drawn on the border when border_en=1.

Ports:
- clk, input, 1: pixel clock.
- reset, input, 1: synchronous, active-high reset.
- resolution, input, 1: 1 selects 800x600, 0 selects 640x480; sampled only at frame start.
- border_en, input, 1: enables the 1-pixel border overlay.
- hs_in, input, 1: horizontal sync from the timing generator.
- vs_in, input, 1: vertical sync from the timing generator.
- hcount, input, 11: current column.
- vcount, input, 11: current line.
- fb_addr, output, ADDR_W: framebuffer read address.
- fb_rd_en, output, 1: framebuffer read strobe.
- fb_rd_data, input, 8: RGB332 read data.
- red, output, 3: red channel.
- green, output, 3: green channel.
- blue, output, 2: blue channel.
- hs_out, output, 1: delayed horizontal sync.
- vs_out, output, 1: delayed vertical sync.
- de_out, output, 1: data enable, aligned with RGB.
- frame_start, output, 1: one-cycle pulse at frame start.

Behaviour:
- Reset (synchronous): all outputs 0; all pipeline stages 0; res_q=0; reset wins over every other event in the same cycle.
- Frame start is defined as hcount==0 and vcount==0 at stage 0. On that cycle:
  - res_q <= resolution.
  - frame_start is asserted at the output stage, aligned with that pixel.
  - A change of resolution mid-frame has no effect until the next frame start.
- Active area:
  - res_q=0: HACT=640, VACT=480, FBW=320.
  - res_q=1: HACT=800, VACT=600, FBW=400.
  - active = (hcount < HACT) && (vcount < VACT).
  - FBW = HACT >> SCALE_SHIFT.
- Address:
  - fb_addr = (vcount >> SCALE_SHIFT) * FBW + (hcount >> SCALE_SHIFT).
  - Computed with a shift-add, no DSP; result truncated to ADDR_W.
  - Maximum address: 119999 at 800x600, 76799 at 640x480.
- Pipeline, with inputs sampled at cycle t:
  - t+1: fb_addr and fb_rd_en registered; fb_rd_en = active. When not active, fb_addr holds its previous value.
  - t+1+RD_LATENCY: fb_rd_data valid.
  - t+2+RD_LATENCY: red/green/blue/de_out/hs_out/vs_out/frame_start registered.
  - Total latency L = RD_LATENCY+2, which is 3 by default.
- Sync path: hs_in/vs_in go through an L-deep shift register. Polarity is passed through unchanged.
- Colour path:
  - de_out = active delayed by L.
  - If de_out=0: RGB = 0.
  - Else if border_en (sampled alongside hcount) and the pixel is on the border (hcount==0, hcount==HACT-1, vcount==0 or vcount==VACT-1): RGB = BORDER_COLOR.
  - Else: red=fb_rd_data[7:5], green=fb_rd_data[4:2], blue=fb_rd_data[1:0].
- Out-of-range counts: hcount or vcount beyond the totals are treated as blanking; no address is issued.
- There is no backpressure; the block issues one read per active pixel, every cycle.

Decomposition:
- Package vga_pkg holds:
  - Timing constants: HACT/VACT/FBW for both modes.
  - RGB332 field positions.
  - The function fb_width(res).
- Sub-module vga_delay_line, parameterised by width and depth, is used for the sync/de/border/frame_start alignment.

Test Plan:
1. Assert reset for 3 cycles with random inputs -> all outputs 0 throughout; fb_rd_en stays 0 on the first post-reset cycle with inactive counts.
2. 640x480, hcount=5, vcount=3 -> fb_addr=1*320+2=322 one cycle later. RAM model returning 8'hB6 -> three cycles after input, red=5, green=5, blue=2, de_out=1.
3. 800x600, hcount=799, vcount=599 -> fb_addr=299*400+399=119999. With hcount=800, vcount=10 -> fb_rd_en=0, and RGB=0 with de_out=0 at L=3.
4. hs_in pulse over hcount 656..751 -> hs_out pulse identical, shifted by exactly 3 cycles. Repeat with RD_LATENCY=3 -> shift of 5.
5. resolution toggled 0->1 at vcount=100 -> addressing stays at FBW=320 until the next hcount=0, vcount=0; frame_start pulses once, 3 cycles later; FBW=400 after that.
6. border_en=1, 640x480, pixels (0,10), (639,10), (10,479), (10,10) -> first three output 8'hE0, i.e. red=7, green=0, blue=0; the last outputs the framebuffer data.

Source files
------------

// File: rtl/vga_pkg.sv
// Shared timing constants, RGB332 field positions and address helpers for the
// VGA pixel generator.
package vga_pkg;

    localparam int HACT_640 = 640;
    localparam int VACT_480 = 480;
    localparam int HACT_800 = 800;
    localparam int VACT_600 = 600;

    localparam int FBW_640 = HACT_640 >> 1;
    localparam int FBW_800 = HACT_800 >> 1;

    localparam int R_MSB = 7;
    localparam int R_LSB = 5;
    localparam int G_MSB = 4;
    localparam int G_LSB = 2;
    localparam int B_MSB = 1;
    localparam int B_LSB = 0;

    typedef struct packed {
        logic hs;
        logic vs;
        logic active;
        logic border;
        logic fs;
    } pix_ctl_t;

    function automatic int fb_width(input logic res, input int shift);
        return (res ? HACT_800 : HACT_640) >> shift;
    endfunction

    // k is a per-mode constant, so this folds into a few fixed adders.
    function automatic logic [21:0] shift_add_mul(input logic [10:0] a,
                                                  input logic [10:0] k);
        logic [21:0] acc;
        acc = '0;
        for (int i = 0; i < 11; i++) begin
            if (k[i]) acc = acc + ({11'b0, a} << i);
        end
        return acc;
    endfunction

endpackage

// File: rtl/vga_pixel_gen_if.sv
// Framebuffer read port between the pixel generator and its synchronous RAM.
// fb_rd_en is a one-cycle read strobe with no ready/backpressure; fb_rd_data
// is valid RD_LATENCY clocks after the registered fb_addr/fb_rd_en.
interface vga_pixel_gen_if #(parameter int ADDR_W = 17) ();
    logic [ADDR_W-1:0] fb_addr;
    logic              fb_rd_en;
    logic [7:0]        fb_rd_data;

    modport master (output fb_addr, output fb_rd_en, input fb_rd_data);
    modport slave  (input fb_addr, input fb_rd_en, output fb_rd_data);
endinterface

// File: rtl/vga_delay_line.sv
// Resettable fixed-depth shift register used to align control with pixel data.
module vga_delay_line #(
    parameter int W     = 1,
    parameter int DEPTH = 1
) (
    input  logic         clk,
    input  logic         reset,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);

    logic [W-1:0] pipe [DEPTH];

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) pipe[i] <= '0;
        end else begin
            pipe[0] <= d;
            for (int i = 1; i < DEPTH; i++) pipe[i] <= pipe[i-1];
        end
    end

    assign q = pipe[DEPTH-1];

endmodule

// File: rtl/vga_pixel_gen.sv
// Raster position to scaled framebuffer address, RGB332 fetch, blanking and
// border overlay, with sync delayed to match the read pipeline.
module vga_pixel_gen
    import vga_pkg::*;
#(
    parameter int          RD_LATENCY   = 1,
    parameter int          ADDR_W       = 17,
    parameter int          SCALE_SHIFT  = 1,
    parameter logic [7:0]  BORDER_COLOR = 8'hE0
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   resolution,
    input  logic                   border_en,
    input  logic                   hs_in,
    input  logic                   vs_in,
    input  logic [10:0]            hcount,
    input  logic [10:0]            vcount,
    vga_pixel_gen_if.master        fb,
    output logic [2:0]             red,
    output logic [2:0]             green,
    output logic [1:0]             blue,
    output logic                   hs_out,
    output logic                   vs_out,
    output logic                   de_out,
    output logic                   frame_start
);

    localparam logic [10:0] K_LO = 11'(fb_width(1'b0, SCALE_SHIFT));
    localparam logic [10:0] K_HI = 11'(fb_width(1'b1, SCALE_SHIFT));

    logic              res_q;
    logic              at_origin;
    logic              res_eff;
    logic [10:0]       hact;
    logic [10:0]       vact;
    logic              active;
    logic              on_border;
    logic [10:0]       h_fb;
    logic [10:0]       v_fb;
    logic [21:0]       row_base;
    logic [ADDR_W-1:0] addr_q;
    logic              rd_en_q;
    pix_ctl_t          ctl_in;
    pix_ctl_t          ctl_dly;

    // The frame-start pixel itself already uses the newly sampled resolution.
    assign at_origin = (hcount == 11'd0) && (vcount == 11'd0);
    assign res_eff   = at_origin ? resolution : res_q;
    assign hact      = res_eff ? 11'(HACT_800) : 11'(HACT_640);
    assign vact      = res_eff ? 11'(VACT_600) : 11'(VACT_480);
    assign active    = (hcount < hact) && (vcount < vact);
    assign on_border = (hcount == 11'd0) || (hcount == hact - 11'd1) ||
                       (vcount == 11'd0) || (vcount == vact - 11'd1);

    assign h_fb     = hcount >> SCALE_SHIFT;
    assign v_fb     = vcount >> SCALE_SHIFT;
    assign row_base = res_eff ? shift_add_mul(v_fb, K_HI) : shift_add_mul(v_fb, K_LO);

    always_ff @(posedge clk) begin
        if (reset) begin
            res_q   <= 1'b0;
            addr_q  <= '0;
            rd_en_q <= 1'b0;
        end else begin
            if (at_origin) res_q <= resolution;
            rd_en_q <= active;
            if (active) addr_q <= ADDR_W'(row_base + {11'b0, h_fb});
        end
    end

    assign fb.fb_addr  = addr_q;
    assign fb.fb_rd_en = rd_en_q;

    assign ctl_in.hs     = hs_in;
    assign ctl_in.vs     = vs_in;
    assign ctl_in.active = active;
    assign ctl_in.border = border_en && on_border;
    assign ctl_in.fs     = at_origin;

    // One stage for the address register plus RD_LATENCY for the RAM; the
    // output register below supplies the final stage.
    vga_delay_line #(
        .W     ($bits(pix_ctl_t)),
        .DEPTH (RD_LATENCY + 1)
    ) u_ctl_dly (
        .clk   (clk),
        .reset (reset),
        .d     (ctl_in),
        .q     (ctl_dly)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            red         <= '0;
            green       <= '0;
            blue        <= '0;
            hs_out      <= 1'b0;
            vs_out      <= 1'b0;
            de_out      <= 1'b0;
            frame_start <= 1'b0;
        end else begin
            hs_out      <= ctl_dly.hs;
            vs_out      <= ctl_dly.vs;
            de_out      <= ctl_dly.active;
            frame_start <= ctl_dly.fs;
            if (!ctl_dly.active) begin
                red   <= '0;
                green <= '0;
                blue  <= '0;
            end else if (ctl_dly.border) begin
                red   <= BORDER_COLOR[R_MSB:R_LSB];
                green <= BORDER_COLOR[G_MSB:G_LSB];
                blue  <= BORDER_COLOR[B_MSB:B_LSB];
            end else begin
                red   <= fb.fb_rd_data[R_MSB:R_LSB];
                green <= fb.fb_rd_data[G_MSB:G_LSB];
                blue  <= fb.fb_rd_data[B_MSB:B_LSB];
            end
        end
    end

endmodule
